icache: RTL and testbench
=========================

ICACHE -- requirements
Module: icache

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 32, address width.
REQ-002 The module SHALL have parameter SETS, default 64, number of sets (index = addr[12:7]).
REQ-003 The module SHALL have parameter WAYS, default 2, associativity (fixed 2-way, 1 LRU bit per set).
REQ-004 The module SHALL have parameter LINE_WORDS, default 32, 32-bit words per line (128 B; word offset = addr[6:2], tag = addr[31:13]).
REQ-005 The module SHALL have port clk, input, 1, sole clock, all state updates on rising edge.
REQ-006 The module SHALL have port rst, input, 1, one clock; reset is synchronous and active-high.
REQ-007 The module SHALL have port icache_if, interface bundle: pc_valid in 1 (fetch request), pc_addr in 32 (byte address, bits [1:0] ignored), instr_valid out 1 (response strobe), instr_data out 32 (fetched word).
REQ-008 The module SHALL have port axi_if, axi_read_if master bundle: araddr out 32, arlen out 8, arsize out 3, arburst out 2, arvalid out 1, arready in 1, rdata in 32, rresp in 2, rlast in 1, rvalid in 1, rready out 1.

Function
REQ-009 The module SHALL use FSM states IDLE, LOOKUP, AR, REFILL, RESP.
REQ-010 IDLE SHALL register pc_addr and go to LOOKUP when pc_valid=1; else stay IDLE.
REQ-011 LOOKUP SHALL compare the registered tag against both ways of the indexed set (hit = valid && tag match).
REQ-012 On hit, LOOKUP SHALL load instr_data with the addressed word of the hit way, set the set's LRU bit to point at the other way, and go to RESP (instr_valid two cycles after pc_valid sampled).
REQ-013 On miss, LOOKUP SHALL select a victim: first invalid way (way 0 preferred), else the way named by the LRU bit, and go to AR.
REQ-014 AR SHALL drive arvalid=1, araddr={tag,index,7'b0}, arlen=31, arsize=2, arburst=INCR (2'b01), holding all stable until arready=1, then go to REFILL.
REQ-015 REFILL SHALL drive rready=1 and write each rdata beat (rvalid=1) into the victim way at incrementing word offset 0..31; rresp SHALL be ignored.
REQ-016 The beat whose offset equals the requested word offset SHALL be captured into instr_data.
REQ-017 On the beat with rlast=1, REFILL SHALL set the victim's valid bit and tag, set LRU to the other way, and go to RESP.
REQ-018 The victim line's valid bit SHALL be cleared on entering REFILL so a partially filled line is never hit.
REQ-019 RESP SHALL assert instr_valid=1 for exactly one cycle with instr_data stable, then go to IDLE.
REQ-020 instr_data SHALL hold its last value while instr_valid=0.
REQ-021 The requester SHALL hold pc_valid/pc_addr stable until instr_valid; pc_valid still high in IDLE after RESP SHALL be accepted as a new request (re-fetch is legal and hits).
REQ-022 arvalid and rready SHALL be 0 in all states other than AR and REFILL respectively.
REQ-023 Only the hit or refill path SHALL modify LRU; lookups with pc_valid=0 SHALL change no state.

Reset
REQ-024 While rst=1, the FSM SHALL go to IDLE and all valid and LRU bits SHALL clear to 0.
REQ-025 While rst=1, instr_valid, arvalid and rready SHALL be 0, and instr_data and araddr SHALL be 0.
REQ-026 Reset asserted mid-AR or mid-REFILL SHALL abandon the transaction with no line left valid; data arrays need no reset.

Verification
REQ-027 Cold miss: after reset, pc_addr=0x00000088 -> one AR with araddr=0x00000080, arlen=31, then after 32 beats instr_valid=1 for one cycle with instr_data = memory word at 0x88.
REQ-028 Hit: repeat 0x00000088 -> no AR, instr_valid two cycles after pc_valid, same data.
REQ-029 Second way: 0x00002088 (tag 1, same index) -> miss fills way 1, araddr=0x00002080.
REQ-030 LRU replace: 0x00004088 (tag 2) -> miss evicts tag 0 (LRU); a later 0x00002088 -> hit with no AR; 0x00000088 -> miss.
REQ-031 Reset mid-REFILL: assert rst during beat 10 -> rready=0, then the same address misses again.
REQ-032 arready stall: hold arready=0 for 5 cycles -> arvalid and araddr stay stable until accepted.

Source files
------------

// File: rtl/icache.sv
// Two-way set-associative instruction cache with a single outstanding
// AXI4 INCR burst refill per miss and one LRU bit per set.
module icache #(
  parameter int ADDR_W     = 32,
  parameter int SETS       = 64,
  parameter int WAYS       = 2,
  parameter int LINE_WORDS = 32
) (
  input  logic              clk,
  input  logic              rst,
  // fetch side
  input  logic              pc_valid,
  input  logic [ADDR_W-1:0] pc_addr,
  output logic              instr_valid,
  output logic [31:0]       instr_data,
  // AXI read master
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic              arvalid,
  input  logic              arready,
  input  logic [31:0]       rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready
);

  localparam int OFF_W   = $clog2(LINE_WORDS);
  localparam int IDX_W   = $clog2(SETS);
  localparam int IDX_LSB = OFF_W + 2;
  localparam int TAG_LSB = IDX_LSB + IDX_W;
  localparam int TAG_W   = ADDR_W - TAG_LSB;
  localparam int RAM_AW  = IDX_W + OFF_W;

  typedef enum logic [2:0] {IDLE, LOOKUP, AR, REFILL, RESP} state_t;

  state_t state_reg, state_next;

  logic [TAG_W-1:0]           tag_reg;
  logic [IDX_W-1:0]           idx_reg;
  logic [OFF_W-1:0]           off_reg;
  logic [OFF_W-1:0]           beat_cnt_reg;
  logic                       victim_reg;
  logic [WAYS-1:0][SETS-1:0]  valid_reg;
  logic [SETS-1:0]            lru_reg;
  logic [31:0]                instr_data_reg;
  logic [ADDR_W-1:0]          araddr_reg;

  logic [WAYS-1:0]  way_hit;
  logic [31:0]      way_data [WAYS];
  logic             any_hit;
  logic             hit_way;
  logic             victim_sel;
  logic             rd_en;
  logic             refill_we;
  logic             tag_we;
  logic [RAM_AW-1:0] rd_addr;
  logic [RAM_AW-1:0] wr_addr;
  logic [IDX_W-1:0]  rd_idx;

  // Byte-lane bits and the response code carry no information for a fetch-only cache.
  logic unused_bits;
  assign unused_bits = ^{rresp, pc_addr[1:0]};

  assign rd_en     = (state_reg == IDLE) && pc_valid;
  assign refill_we = (state_reg == REFILL) && rvalid && !rst;
  assign tag_we    = refill_we && rlast;
  assign rd_addr   = pc_addr[TAG_LSB-1:2];
  assign rd_idx    = pc_addr[TAG_LSB-1:IDX_LSB];
  assign wr_addr   = {idx_reg, beat_cnt_reg};

  // Per-way data and tag RAMs; the read is issued while the request is
  // accepted in IDLE so the registered word is ready for the LOOKUP compare.
  generate
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
      logic [31:0]      data_mem [SETS*LINE_WORDS];
      logic [TAG_W-1:0] tag_mem  [SETS];
      logic [31:0]      data_rd_reg;
      logic [TAG_W-1:0] tag_rd_reg;
      logic             way_sel;

      assign way_sel = (victim_reg == 1'(gi));

      always_ff @(posedge clk) begin
        if (refill_we && way_sel) begin
          data_mem[wr_addr] <= rdata;
        end
        if (tag_we && way_sel) begin
          tag_mem[idx_reg] <= tag_reg;
        end
        if (rd_en) begin
          data_rd_reg <= data_mem[rd_addr];
          tag_rd_reg  <= tag_mem[rd_idx];
        end
      end

      assign way_data[gi] = data_rd_reg;
      assign way_hit[gi]  = valid_reg[gi][idx_reg] && (tag_rd_reg == tag_reg);
    end
  endgenerate

  assign any_hit = |way_hit;
  assign hit_way = !way_hit[0];

  // Fill an empty way first (way 0 preferred) before evicting the LRU way.
  always_comb begin
    victim_sel = lru_reg[idx_reg];
    if (!valid_reg[0][idx_reg]) begin
      victim_sel = 1'b0;
    end else if (!valid_reg[1][idx_reg]) begin
      victim_sel = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (pc_valid) state_next = LOOKUP;
      LOOKUP:  state_next = any_hit ? RESP : AR;
      AR:      if (arready) state_next = REFILL;
      REFILL:  if (rvalid && rlast) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_reg        <= '0;
      idx_reg        <= '0;
      off_reg        <= '0;
      beat_cnt_reg   <= '0;
      victim_reg     <= 1'b0;
      valid_reg      <= '0;
      lru_reg        <= '0;
      instr_data_reg <= '0;
      araddr_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pc_valid) begin
            tag_reg <= pc_addr[ADDR_W-1:TAG_LSB];
            idx_reg <= pc_addr[TAG_LSB-1:IDX_LSB];
            off_reg <= pc_addr[IDX_LSB-1:2];
          end
        end
        LOOKUP: begin
          if (any_hit) begin
            instr_data_reg   <= way_data[hit_way];
            lru_reg[idx_reg] <= !hit_way;
          end else begin
            victim_reg <= victim_sel;
            araddr_reg <= {tag_reg, idx_reg, {IDX_LSB{1'b0}}};
          end
        end
        AR: begin
          // Invalidate the victim before any beat lands so a half-filled
          // line can never produce a hit.
          if (arready) begin
            valid_reg[victim_reg][idx_reg] <= 1'b0;
            beat_cnt_reg <= '0;
          end
        end
        REFILL: begin
          if (rvalid) begin
            beat_cnt_reg <= beat_cnt_reg + OFF_W'(1);
            if (beat_cnt_reg == off_reg) begin
              instr_data_reg <= rdata;
            end
            if (rlast) begin
              valid_reg[victim_reg][idx_reg] <= 1'b1;
              lru_reg[idx_reg] <= !victim_reg;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    instr_valid = 1'b0;
    arvalid     = 1'b0;
    rready      = 1'b0;
    if (!rst) begin
      instr_valid = (state_reg == RESP);
      arvalid     = (state_reg == AR);
      rready      = (state_reg == REFILL);
    end
  end

  assign instr_data = instr_data_reg;
  assign araddr     = araddr_reg;
  assign arlen      = 8'(LINE_WORDS - 1);
  assign arsize     = 3'd2;
  assign arburst    = 2'b01;

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: table of fetches against a behavioural AXI
// memory, plus hand-written reset-during-refill sequence.
module tb_icache;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_valid;
  logic [31:0] pc_addr;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  always #5 clk = ~clk;

  icache dut (
    .clk        (clk),
    .rst        (rst),
    .pc_valid   (pc_valid),
    .pc_addr    (pc_addr),
    .instr_valid(instr_valid),
    .instr_data (instr_data),
    .araddr     (araddr),
    .arlen      (arlen),
    .arsize     (arsize),
    .arburst    (arburst),
    .arvalid    (arvalid),
    .arready    (arready),
    .rdata      (rdata),
    .rresp      (rresp),
    .rlast      (rlast),
    .rvalid     (rvalid),
    .rready     (rready)
  );

  typedef struct {
    logic [31:0] addr;
    bit          miss;
    logic [31:0] exp_araddr;
    int          stall;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] sb_q [$];
  vec_t        vecs [13];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a & 32'hFFFF_FFFC) * 32'h9E37_79B1 + 32'h0135_7BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_instr_valid"}, 32'(instr_valid), 32'd0);
    check({tag, "_arvalid"},     32'(arvalid),     32'd0);
    check({tag, "_rready"},      32'(rready),      32'd0);
    check({tag, "_instr_data"},  instr_data,       32'd0);
    check({tag, "_araddr"},      araddr,           32'd0);
  endtask

  // One fetch: acts as the AXI slave, pops the scoreboard on instr_valid.
  task automatic fetch(input logic [31:0] a, input bit exp_miss,
                       input logic [31:0] exp_ar, input int stall);
    int          cyc = 0;
    int          beat = 0;
    int          ar_wait = 0;
    int          ar_cnt = 0;
    bit          got = 0;
    logic [31:0] first_ar = '0;
    logic [31:0] line;
    logic [31:0] exp_d;
    logic [31:0] data_seen = '0;
    line = a & 32'hFFFF_FF80;
    pc_valid = 1'b1;
    pc_addr  = a;
    sb_q.push_back(mem_word(a));
    while (!got && cyc < 200) begin
      @(negedge clk);
      cyc++;
      arready = 1'b0;
      rvalid  = 1'b0;
      rlast   = 1'b0;
      if (instr_valid) begin
        got = 1;
        pc_valid = 1'b0;
        exp_d = sb_q.pop_front();
        data_seen = instr_data;
        check("instr_data", instr_data, exp_d);
        check("ar_count", 32'(ar_cnt), exp_miss ? 32'd1 : 32'd0);
        if (exp_miss) check("beats", 32'(beat), 32'd32);
        else          check("hit_latency", 32'(cyc), 32'd2);
      end else begin
        if (arvalid) begin
          if (ar_wait == 0) begin
            first_ar = araddr;
            check("araddr", araddr, exp_ar);
            check("arlen", 32'(arlen), 32'd31);
            check("arsize", 32'(arsize), 32'd2);
            check("arburst", 32'(arburst), 32'd1);
          end else begin
            check("araddr_stable", araddr, first_ar);
          end
          ar_wait++;
          if (ar_wait > stall) begin
            arready = 1'b1;
            ar_cnt++;
          end
        end
        if (rready) begin
          rvalid = 1'b1;
          rdata  = mem_word(line + 32'(beat) * 4);
          rresp  = 2'b10;
          rlast  = (beat == 31);
          beat++;
        end
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL timeout: addr %h got no instr_valid, required one within 200 cycles", a);
      pc_valid = 1'b0;
      void'(sb_q.pop_back());
    end else begin
      @(negedge clk);
      check("instr_valid_one_cycle", 32'(instr_valid), 32'd0);
      check("instr_data_hold", instr_data, data_seen);
    end
    $display("fetch addr=%h miss=%0d araddr=%h data=%h", a, exp_miss, first_ar, data_seen);
  endtask

  initial begin
    bit hit_beat10;
    int beat;
    vecs[0]  = '{32'h0000_0088, 1'b1, 32'h0000_0080, 0};
    vecs[1]  = '{32'h0000_0088, 1'b0, 32'h0,         0};
    vecs[2]  = '{32'h0000_2088, 1'b1, 32'h0000_2080, 0};
    vecs[3]  = '{32'h0000_4088, 1'b1, 32'h0000_4080, 5};
    vecs[4]  = '{32'h0000_2088, 1'b0, 32'h0,         0};
    vecs[5]  = '{32'h0000_0088, 1'b1, 32'h0000_0080, 0};
    vecs[6]  = '{32'h0000_2088, 1'b0, 32'h0,         0};
    vecs[7]  = '{32'h0000_0100, 1'b1, 32'h0000_0100, 2};
    vecs[8]  = '{32'h0000_017C, 1'b0, 32'h0,         0};
    vecs[9]  = '{32'h0000_1F84, 1'b1, 32'h0000_1F80, 0};
    vecs[10] = '{32'hFFFF_E07C, 1'b1, 32'hFFFF_E000, 0};
    vecs[11] = '{32'hFFFF_E07F, 1'b0, 32'h0,         0};
    vecs[12] = '{32'h0000_0088, 1'b0, 32'h0,         0};

    rst = 1'b1;
    pc_valid = 1'b0;
    pc_addr = '0;
    arready = 1'b0;
    rdata = '0;
    rresp = '0;
    rlast = 1'b0;
    rvalid = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      fetch(vecs[i].addr, vecs[i].miss, vecs[i].exp_araddr, vecs[i].stall);
    end

    // Reset arrives together with refill beat 10.
    hit_beat10 = 0;
    beat = 0;
    pc_valid = 1'b1;
    pc_addr  = 32'h0000_8088;
    for (int c = 0; c < 200 && !hit_beat10; c++) begin
      @(negedge clk);
      arready = arvalid;
      rvalid = 1'b0;
      rlast = 1'b0;
      if (rready) begin
        rvalid = 1'b1;
        rdata  = mem_word(32'h0000_8080 + 32'(beat) * 4);
        if (beat == 10) begin
          rst = 1'b1;
          hit_beat10 = 1;
        end
        beat++;
      end
    end
    if (!hit_beat10) begin
      checks++;
      errors++;
      $display("FAIL refill_start: got no beat 10, required refill to reach it");
    end
    @(negedge clk);
    check_idle_outputs("mid_refill_reset");
    $display("reset asserted during refill beat 10 of addr 00008088");
    rst = 1'b0;
    pc_valid = 1'b0;
    rvalid = 1'b0;
    arready = 1'b0;
    @(negedge clk);
    fetch(32'h0000_8088, 1'b1, 32'h0000_8080, 0);
    fetch(32'h0000_0088, 1'b1, 32'h0000_0080, 0);
    fetch(32'h0000_8088, 1'b0, 32'h0, 0);

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
